// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result port, long-latency result port,
// register-file write port and FIFO occupancy. Port summary: alu_valid/ready/rd/data,
// ext_valid/ready/rd/data, wen/regW_sel/regW_i, fifo_count. master = arbiter side.
interface wb_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  logic                          alu_valid;
  logic                          alu_ready;
  logic [4:0]                    alu_rd;
  logic [31:0]                   alu_data;
  logic                          ext_valid;
  logic                          ext_ready;
  logic [4:0]                    ext_rd;
  logic [31:0]                   ext_data;
  logic                          wen;
  logic [4:0]                    regW_sel;
  logic [31:0]                   regW_i;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // Arbiter side: consumes results, drives the register-file write port.
  modport master (
    input  alu_valid, alu_rd, alu_data, ext_valid, ext_rd, ext_data,
    output alu_ready, ext_ready, wen, regW_sel, regW_i, fifo_count
  );

  // Environment side: pipeline, long-latency unit and register file.
  modport slave (
    output alu_valid, alu_rd, alu_data, ext_valid, ext_rd, ext_data,
    input  alu_ready, ext_ready, wen, regW_sel, regW_i, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered long-latency results
// onto the single register-file write port. ALU wins unless the FIFO head has lost
// STARVE_LIMIT times in a row. Ports: clk, rst_n, bus (wb_arbiter_if.master).
// Latency: ALU 1 cycle, ext >= 2 cycles. Backpressure: alu_ready low only in FORCE,
// ext_ready = !full. Optional macro WB_X0_FILTER_EN suppresses wen for rd==0.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_arbiter_if.master     bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    starve_cnt;
  logic [4:0]    rd_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];

  logic          wen_q;
  logic [4:0]    sel_q;
  logic [31:0]   dat_q;

  logic          empty, full, push;
  logic          grant_alu, grant_fifo;
  logic [4:0]    g_rd;
  logic [31:0]   g_data;
  logic [3:0]    starve_nxt;
  logic          wr_en;

  always_comb begin
    empty      = (count == '0);
    full       = (count == CW'(FIFO_DEPTH));
    // Enqueue never looks at this cycle's dequeue: readiness comes from the registered count.
    push       = bus.ext_valid && !full;
    grant_alu  = (state == NORMAL) && bus.alu_valid;
    // FORCE is only ever entered with a non-empty FIFO, so no empty check is needed there.
    grant_fifo = (state == FORCE) || (!bus.alu_valid && !empty);
    g_rd       = grant_fifo ? rd_mem[rd_ptr]   : bus.alu_rd;
    g_data     = grant_fifo ? data_mem[rd_ptr] : bus.alu_data;

    starve_nxt = starve_cnt;
    if (grant_fifo || empty)
      starve_nxt = '0;
    else if (grant_alu && starve_cnt != 4'(STARVE_LIMIT))
      starve_nxt = starve_cnt + 4'd1;

`ifdef WB_X0_FILTER_EN
    wr_en = (g_rd != 5'd0);
`else
    wr_en = 1'b1;
`endif
  end

  assign bus.ext_ready  = !full;
  assign bus.alu_ready  = (state == NORMAL);
  assign bus.wen        = wen_q;
  assign bus.regW_sel   = sel_q;
  assign bus.regW_i     = dat_q;
  assign bus.fifo_count = count;

  // Storage carries no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= bus.ext_rd;
      data_mem[wr_ptr] <= bus.ext_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      wen_q      <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
    end else begin
      // Pointer width equals log2(depth), so increment wraps modulo depth.
      if (push)       wr_ptr <= wr_ptr + PW'(1);
      if (grant_fifo) rd_ptr <= rd_ptr + PW'(1);

      case ({push, grant_fifo})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      starve_cnt <= starve_nxt;
      // Saturation only occurs while the FIFO holds something, so the
      // saturated count alone identifies FORCE for the next cycle.
      state <= (starve_nxt == 4'(STARVE_LIMIT)) ? FORCE : NORMAL;

      if (grant_alu || grant_fifo) begin
        wen_q <= wr_en;
        sel_q <= g_rd;
        dat_q <= g_data;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side driver for the RV32I register file: produces the single write port (wen, regW_sel, regW_i) from two result sources.
- Sources: the in-order pipeline ALU/writeback result, and a long-latency unit (load/mul-div) with a valid/ready handshake buffered in a small FIFO.
- ALU results have priority. A starvation counter bounds how long the long-latency source can wait. Outputs are registered.

Parameters:
- FIFO_DEPTH, 2, long-latency buffer entries; power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before it is forced through; 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  combinational; ALU result accepted this cycle; pipeline stalls when low.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ext_valid  in  1  long-latency result offered.
- ext_ready  out  1  combinational; equals !full.
- ext_rd  in  5  long-latency destination register.
- ext_data  in  32  long-latency result.
- wen  out  1  registered register-file write enable.
- regW_sel  out  5  registered write address.
- regW_i  out  32  registered write data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  registered FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by the register clocking): wen=0, regW_sel=0, regW_i=0, fifo_count=0, FIFO pointers=0, starve_cnt=0, state=NORMAL. Any in-flight FIFO entries are discarded.
- Enqueue: ext_valid && ext_ready pushes {ext_rd, ext_data} at the write pointer.
  - ext_ready depends only on the registered count. There is no enqueue when full, even if a dequeue happens in the same cycle.
- States:
  - NORMAL: starve_cnt < STARVE_LIMIT.
  - FORCE: starve_cnt == STARVE_LIMIT and FIFO non-empty.
- Grant in NORMAL:
  - alu_valid: grant ALU, alu_ready=1.
  - else FIFO non-empty: grant FIFO (dequeue head).
  - else: no grant.
- Grant in FORCE: grant FIFO, alu_ready=0. The ALU holds its inputs stable.
- alu_ready=1 in NORMAL regardless of alu_valid; alu_ready=0 only in FORCE.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when the FIFO is non-empty and the ALU is granted.
  - Cleared on any FIFO grant, or when the FIFO is empty.
  - FORCE returns to NORMAL on the cycle after the forced dequeue.
- Output: on the posedge after a grant, wen=1 and regW_sel/regW_i carry the granted entry.
  - With no grant, wen=0 and regW_sel/regW_i hold their last values.
  - Latency: ALU 1 cycle. Ext at least 2 cycles (enqueue edge, then dequeue edge); there is no bypass.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Ordering:
  - FIFO entries are written in arrival order.
  - No ordering is enforced between ALU and ext writes to the same rd; hazard avoidance belongs to the issue logic.
- fifo_count = entries after the edge's push/pop.

Optional Feature:
- Macro: WB_X0_FILTER_EN.
- Defined: a granted entry with rd==0 is consumed normally (dequeued/accepted, and counts as a grant for starvation), but the registered wen stays 0.
- Undefined: rd==0 writes assert wen=1 like any other; the register file's read-side zeroing hides them.

Test Plan:
- Reset mid-traffic: FIFO holds 2 entries, assert rst_n=0 asynchronously -> wen=0 and fifo_count=0 immediately, no further writes after release.
- ALU only: alu_valid with rd=5, data=0xDEADBEEF -> next edge wen=1, regW_sel=5, regW_i=0xDEADBEEF; alu_ready stays 1.
- Ext only: one push of rd=10, data=0x1234 at edge N -> wen=1 with that entry after edge N+1; fifo_count goes 1 then 0.
- Full FIFO: 3 back-to-back ext pushes while alu_valid=1 continuously -> ext_ready=0 after 2 pushes, third held until space.
- Starvation: FIFO non-empty, alu_valid=1 for 10 cycles, STARVE_LIMIT=4 -> 4 ALU writes, then alu_ready=0 for 1 cycle, then a FIFO write, then ALU resumes; no ALU result lost or duplicated.
- x0 write with rd=0, data=0xFFFFFFFF, run both builds -> wen=0 with WB_X0_FILTER_EN defined, wen=1 without; fifo_count decrements in both.
